// File: rtl/monit_scheduler.sv
// monit_scheduler: periodic sample strobe, buffer fill tracking and one-frame-at-a-time transmit sequencing.
module monit_scheduler #(
  parameter int PERIOD_WIDTH   = 32,
  parameter int DEFAULT_PERIOD = 255,
  parameter int DEPTH          = 16,
  parameter int LEVEL_WIDTH    = 5,
  parameter int TX_TIMEOUT     = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    periodLoad,
  input  logic [PERIOD_WIDTH-1:0] periodIn,
  input  logic                    doneTx,
  input  logic                    overflowClear,
  output logic                    wr_enable,
  output logic                    rd_enable,
  output logic                    startComm,
  output logic                    busy,
  output logic [LEVEL_WIDTH-1:0]  fillLevel,
  output logic                    overflow,
  output logic                    txError,
  output logic [15:0]             sampleCount
);
  localparam int TW = $clog2(TX_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, POP, SETTLE, START, WAIT} state_t;
  state_t state_q, state_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d, cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic [15:0] scount_q, scount_d;
  logic wr_q, wr_d, rd_q, start_q, busy_q, ovf_q, ovf_d, txerr_q, txerr_d;
  logic due, pop, full, tx_to;
  always_comb begin
    due      = enable && !periodLoad && cnt_q == period_q;
    full     = level_q == LEVEL_WIDTH'(DEPTH);
    pop      = state_q == IDLE && enable && level_q != '0;
    period_d = periodLoad ? periodIn : period_q;
    cnt_d    = (!enable || periodLoad || due) ? '0 : cnt_q + PERIOD_WIDTH'(1);
    wr_d     = due && (!full || pop);
    level_d  = level_q + LEVEL_WIDTH'(wr_d) - LEVEL_WIDTH'(pop);
    scount_d = scount_q + 16'(wr_d);
    ovf_d    = (due && full && !pop) || (ovf_q && !overflowClear);
    tx_to    = state_q == WAIT && !doneTx && tcnt_q == TW'(TX_TIMEOUT);
    txerr_d  = tx_to || (txerr_q && !overflowClear);
  end
  // Outputs below are registered from the next state so they align with the state they describe.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      IDLE:    state_d = pop ? POP : IDLE;
      POP:     state_d = SETTLE;
      SETTLE:  state_d = START;
      START: begin
        state_d = WAIT;
        tcnt_d  = '0;
      end
      WAIT: begin
        state_d = (doneTx || tx_to) ? IDLE : WAIT;
        tcnt_d  = (doneTx || tx_to) ? tcnt_q : tcnt_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      period_q <= PERIOD_WIDTH'(DEFAULT_PERIOD);
      cnt_q    <= '0;
      tcnt_q   <= '0;
      level_q  <= '0;
      scount_q <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      txerr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      tcnt_q   <= tcnt_d;
      level_q  <= level_d;
      scount_q <= scount_d;
      wr_q     <= wr_d;
      rd_q     <= state_d == POP;
      start_q  <= state_d == START;
      busy_q   <= state_d != IDLE;
      ovf_q    <= ovf_d;
      txerr_q  <= txerr_d;
    end
  end
  assign wr_enable   = wr_q;
  assign rd_enable   = rd_q;
  assign startComm   = start_q;
  assign busy        = busy_q;
  assign fillLevel   = level_q;
  assign overflow    = ovf_q;
  assign txError     = txerr_q;
  assign sampleCount = scount_q;
endmodule

// File: tb/tb_monit_scheduler.sv
// tb_monit_scheduler: strobe-timing scoreboard, period table and hand sequences for framing, overflow, timeout and reset.
module tb_monit_scheduler;
  logic clk = 0, rst = 0, enable = 1, periodLoad = 0, doneTx = 0, overflowClear = 0;
  logic [31:0] periodIn = 0;
  logic wr_enable, rd_enable, startComm, busy, overflow, txError;
  logic [4:0] fillLevel;
  logic [15:0] sampleCount;
  int cyc = 0, checks = 0, errors = 0, run = 0, last_run = 0;
  bit sb_on = 0;
  int exp_q[$];
  typedef struct {int p; int n;} vec_t;
  vec_t tbl[4];

  monit_scheduler dut (
    .clk(clk), .rst(rst), .enable(enable), .periodLoad(periodLoad), .periodIn(periodIn),
    .doneTx(doneTx), .overflowClear(overflowClear), .wr_enable(wr_enable), .rd_enable(rd_enable),
    .startComm(startComm), .busy(busy), .fillLevel(fillLevel), .overflow(overflow),
    .txError(txError), .sampleCount(sampleCount)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Each strobe is matched against the cycle the scoreboard expected when the stimulus was driven.
  always @(negedge clk) begin
    if (busy) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
    if (sb_on && !rst && wr_enable) begin
      if (exp_q.size() == 0) chk("unexpected_wr", cyc, -1);
      else chk("wr_time", cyc, exp_q.pop_front());
    end
  end

  initial begin
    int r0, l, t, u, c;
    tbl[0] = '{9, 3}; tbl[1] = '{0, 3}; tbl[2] = '{2, 3}; tbl[3] = '{4, 2};
    #1 rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_wr", wr_enable, 0); chk("rst_rd", rd_enable, 0); chk("rst_start", startComm, 0);
    chk("rst_busy", busy, 0); chk("rst_level", fillLevel, 0); chk("rst_ovf", overflow, 0);
    chk("rst_txerr", txError, 0); chk("rst_scount", sampleCount, 0);
    rst = 0; r0 = cyc;
    for (int k = 1; k <= 3; k++) exp_q.push_back(r0 + 256 * k);
    sb_on = 1;
    wait_cyc(r0 + 256); chk("s1_level", fillLevel, 1); chk("s1_scount", sampleCount, 1); chk("s1_busy", busy, 0);
    wait_cyc(r0 + 257); chk("pop_rd", rd_enable, 1); chk("pop_level", fillLevel, 0); chk("pop_busy", busy, 1);
    wait_cyc(r0 + 258); chk("settle_rd", rd_enable, 0); chk("settle_start", startComm, 0);
    wait_cyc(r0 + 259); chk("start_pulse", startComm, 1);
    wait_cyc(r0 + 260); chk("start_end", startComm, 0);
    wait_cyc(r0 + 359); doneTx = 1;
    wait_cyc(r0 + 360); doneTx = 0; chk("frame_end_busy", busy, 0);
    wait_cyc(r0 + 361); chk("busy_len", last_run, 103);
    wait_cyc(r0 + 770);
    chk("sb_drain1", exp_q.size(), 0); chk("p1_scount", sampleCount, 3);
    chk("p1_level", fillLevel, 1); chk("p1_busy", busy, 1);
    sb_on = 0;
    l = cyc; periodIn = 0; periodLoad = 1;
    @(negedge clk); periodLoad = 0;
    wait_cyc(l + 16); chk("full_level", fillLevel, 16); chk("full_wr", wr_enable, 1);
    chk("full_scount", sampleCount, 18); chk("full_ovf", overflow, 0);
    wait_cyc(l + 17); chk("ovf_wr", wr_enable, 0); chk("ovf_set", overflow, 1);
    chk("ovf_level", fillLevel, 16); chk("ovf_scount", sampleCount, 18);
    wait_cyc(l + 20); chk("ovf_sticky", overflow, 1); overflowClear = 1;
    wait_cyc(l + 21); chk("ovf_set_wins", overflow, 1); enable = 0;
    wait_cyc(l + 22); chk("ovf_cleared", overflow, 0); chk("dis_wr", wr_enable, 0); overflowClear = 0;
    wait_cyc(r0 + 66051); chk("to_txerr_pre", txError, 0); chk("to_busy_pre", busy, 1);
    wait_cyc(r0 + 66052); chk("to_txerr", txError, 1); chk("to_busy", busy, 0);
    wait_cyc(r0 + 66055); chk("dis_busy", busy, 0); chk("dis_level", fillLevel, 16); chk("dis_ovf", overflow, 0);
    overflowClear = 1;
    wait_cyc(r0 + 66056); chk("txerr_clear", txError, 0);
    overflowClear = 0; enable = 1; t = cyc;
    wait_cyc(t + 1); chk("fullpop_rd", rd_enable, 1); chk("fullpop_wr", wr_enable, 1);
    chk("fullpop_level", fillLevel, 16); chk("fullpop_scount", sampleCount, 19);
    wait_cyc(t + 2); chk("full2_wr", wr_enable, 0); chk("full2_ovf", overflow, 1); chk("full2_level", fillLevel, 16);
    wait_cyc(t + 3); chk("f3_start", startComm, 1);
    wait_cyc(t + 5);
    rst = 1; doneTx = 1; enable = 0;
    #1;
    chk("arst_wr", wr_enable, 0); chk("arst_rd", rd_enable, 0); chk("arst_start", startComm, 0);
    chk("arst_busy", busy, 0); chk("arst_level", fillLevel, 0); chk("arst_ovf", overflow, 0);
    chk("arst_txerr", txError, 0); chk("arst_scount", sampleCount, 0);
    wait_cyc(t + 7); rst = 0;
    wait_cyc(t + 8); chk("stale_done_busy", busy, 0); chk("stale_done_start", startComm, 0);
    chk("stale_done_rd", rd_enable, 0);
    doneTx = 0; enable = 1; u = cyc;
    sb_on = 1;
    c = u + 100;
    for (int i = 0; i < 4; i++) begin
      wait_cyc(c);
      periodIn = tbl[i].p; periodLoad = 1;
      for (int k = 1; k <= tbl[i].n; k++) exp_q.push_back(c + 1 + k * (tbl[i].p + 1));
      @(negedge clk); periodLoad = 0;
      chk("tbl_queue", exp_q.size(), tbl[i].n);
      c = c + 1 + tbl[i].n * (tbl[i].p + 1);
    end
    wait_cyc(c); enable = 0;
    @(negedge clk);
    chk("tbl_drain", exp_q.size(), 0); chk("tbl_scount", sampleCount, 11); chk("tbl_level", fillLevel, 10);
    sb_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
